// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// The MULDIV_FAST_MULT_EN build macro (see mips_muldiv_unit) uses these unchanged.
package mips_muldiv_pkg;

  localparam int unsigned MD_ITER       = 32;
  localparam logic [31:0] MD_DIVZERO_LO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_t;

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring shift-subtract divide.
// Accumulator holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
module mips_muldiv_step #(
  parameter int unsigned W = 32
) (
  input  logic             is_div,
  input  logic [2*W-1:0]   acc_in,
  input  logic [W-1:0]     m,
  output logic [2*W-1:0]   acc_out
);

  logic [W:0]   sum;
  logic [W:0]   trial;
  logic [W-1:0] diff;
  logic         ge;

  always_comb begin
    sum   = {1'b0, acc_in[2*W-1:W]} + (acc_in[0] ? {1'b0, m} : '0);
    trial = {acc_in[2*W-1:W], acc_in[W-1]};
    ge    = (trial >= {1'b0, m});
    // When ge holds the true difference is below m, so modular W-bit subtraction is exact.
    diff  = trial[W-1:0] - m;
    if (is_div) begin
      acc_out = {(ge ? diff : trial[W-1:0]), acc_in[W-2:0], ge};
    end else begin
      acc_out = {sum, acc_in[W-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO abort any operation in flight.
// Build macro MULDIV_FAST_MULT_EN: MULT/MULTU commit in a single cycle; divides stay iterative.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ITER   = MD_ITER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = $clog2(ITER);

  md_state_t           state_q, state_d;
  md_op_t              op_q, op_d;
  logic                sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, acc_step;
  logic [CntW-1:0]     cnt_q, cnt_d;

  md_op_t              start_op;
  logic                start_sa, start_sb, start_div;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo, rem;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*DATA_W-1:0] fast_mag;
`endif

  mips_muldiv_step #(
    .W (DATA_W)
  ) u_step (
    .is_div  (md_is_div(op_q)),
    .acc_in  (acc_q),
    .m       (m_q),
    .acc_out (acc_step)
  );

  always_comb begin
    start_op  = md_op_t'(op_code);
    start_div = md_is_div(start_op);
    start_sa  = md_is_signed(start_op) & op_a[DATA_W-1];
    start_sb  = md_is_signed(start_op) & op_b[DATA_W-1];
    abs_a     = start_sa ? -op_a : op_a;
    abs_b     = start_sb ? -op_b : op_b;
`ifdef MULDIV_FAST_MULT_EN
    fast_mag  = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
`endif
    prod      = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo       = (sa_q ^ sb_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem       = sa_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (hi_we || lo_we) begin
      // An MT write abandons any operation and beats a simultaneous op_start.
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
      state_d = IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (op_start) begin
      op_d  = start_op;
      sa_d  = start_sa;
      sb_d  = start_sb;
      dz_d  = (op_b == '0);
      cnt_d = '0;
      if (start_div) begin
        acc_d = {{DATA_W{1'b0}}, abs_a};
        m_d   = abs_b;
      end else begin
        acc_d = {{DATA_W{1'b0}}, abs_b};
        m_d   = abs_a;
      end
      state_d = RUN;
      busy_d  = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
      if (!start_div) begin
        {hi_d, lo_d} = (start_sa ^ start_sb) ? -fast_mag : fast_mag;
        done_d       = 1'b1;
        state_d      = IDLE;
        busy_d       = 1'b0;
      end
`endif
    end else begin
      unique case (state_q)
        RUN: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER - 1)) state_d = FIX;
        end
        FIX: begin
          if (md_is_div(op_q)) begin
            // Divide by zero: the remainder path already reproduces op_a, only LO is forced.
            lo_d = dz_q ? {DATA_W{1'b1}} : quo;
            hi_d = rem;
          end else begin
            {hi_d, lo_d} = prod;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: arithmetic reference model plus directed literal checks.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_start = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mips_muldiv_unit #(
    .DATA_W (32),
    .ITER   (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_start (op_start),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model_result(input logic [1:0] code, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      2'b00: r = sa * sb;
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  // Each operation takes 33 edges from issue to commit.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (hi_we || lo_we) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        m_busy <= 1'b0;
      end else if (op_start) begin
`ifdef MULDIV_FAST_MULT_EN
        if (!op_code[1]) begin
          {m_hi, m_lo} <= model_result(op_code, op_a, op_b);
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end else
`endif
        begin
          m_pend <= model_result(op_code, op_a, op_b);
          m_busy <= 1'b1;
          m_left <= 33;
        end
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= m_pend;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
      check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      check("cyc_done", {31'b0, done}, {31'b0, m_done});
    end
  end

  task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_start = 1'b1; op_code = c; op_a = a; op_b = b;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, {31'b0, done}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(c, a, b);
    wait_done(name);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    check({name, "_model_hi"}, m_hi, exp_hi);
    check({name, "_model_lo"}, m_lo, exp_lo);
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    hi_we = h; lo_we = l; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    int nbusy;
    int ndone;
    #1 reset = 1'b0;
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cmp_en = 1'b1;

    // First MULT: busy duration and a single done pulse.
    issue(2'b00, 32'h40000000, 32'h00020001);
    nbusy = 0;
    ndone = 0;
    while (busy && nbusy < 100) begin
      if (done) ndone++;
      nbusy++;
      @(negedge clk);
    end
`ifndef MULDIV_FAST_MULT_EN
    check("mult1_busy_cycles", nbusy, 33);
    check("mult1_done_during_busy", ndone, 0);
`endif
    check("mult1_done", {31'b0, done}, 32'd1);
    check("mult1_hi", hi, 32'h00008000);
    check("mult1_lo", lo, 32'h40000000);
    @(negedge clk);
    check("mult1_done_once", {31'b0, done}, 32'd0);

    run_op("mult_neg1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_mix", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_neg7", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7_2", 2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
    run_op("div_by0", 2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
    run_op("div_neg_by0", 2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("divu_by0", 2'b11, 32'h80000001, 32'h00000000, 32'h80000001, 32'hFFFFFFFF);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_7_neg2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // MT writes while idle.
    mt_write(1'b1, 1'b0, 32'h40000000);
    check("mthi_hi", hi, 32'h40000000);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    mt_write(1'b0, 1'b1, 32'h00020001);
    check("mtlo_lo", lo, 32'h00020001);
    check("mtlo_hi_kept", hi, 32'h40000000);

    // MTLO during a MULT aborts it; HI keeps its pre-operation value.
    issue(2'b00, 32'h00000003, 32'h00000004);
    repeat (8) @(negedge clk);
    mt_write(1'b0, 1'b1, 32'h00001234);
    check("abort_lo", lo, 32'h00001234);
`ifdef MULDIV_FAST_MULT_EN
    check("abort_hi", hi, 32'h00000000);
`else
    check("abort_hi", hi, 32'h40000000);
`endif
    check("abort_busy", {31'b0, busy}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);

    // op_start and MTHI on the same edge: the write wins.
    @(negedge clk);
    op_start = 1'b1; op_code = 2'b11; op_a = 32'd7; op_b = 32'd2;
    hi_we = 1'b1; wdata = 32'h0000ABCD;
    @(negedge clk);
    op_start = 1'b0; hi_we = 1'b0;
    check("mt_wins_hi", hi, 32'h0000ABCD);
    check("mt_wins_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("mt_wins_lo_kept", lo, 32'h00001234);

    // Restart while busy.
    issue(2'b10, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    run_op("restart", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);

    // Asynchronous reset mid-operation.
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("post_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
